// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline interlock controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } interlock_state_e;

  localparam int unsigned REG_ZERO = 0;

  localparam int unsigned LOAD_STALL_MIN = 1;
  localparam int unsigned LOAD_STALL_MAX = 7;
  localparam int unsigned LU_CNT_W       = 3;

  // Out-of-range bubble counts saturate into the supported window.
  function automatic int unsigned clamp_load_stall(input int unsigned n);
    if (n < LOAD_STALL_MIN) return LOAD_STALL_MIN;
    if (n > LOAD_STALL_MAX) return LOAD_STALL_MAX;
    return n;
  endfunction

endpackage

// File: rtl/pipeline_interlock_ctrl_load_use_detect.sv
// Load-use hazard detector: EX load whose destination feeds a source read in ID.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_IDX_W = 5
) (
  input  logic [REG_IDX_W-1:0] id_rs1_idx_i,
  input  logic [REG_IDX_W-1:0] id_rs2_idx_i,
  input  logic                 id_use_rs1_i,
  input  logic                 id_use_rs2_i,
  input  logic [REG_IDX_W-1:0] ex_rd_idx_i,
  input  logic                 ex_is_load_i,
  output logic                 load_use_o
);

  logic rd_nonzero;
  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rd_nonzero = (ex_rd_idx_i != REG_IDX_W'(REG_ZERO));
    rs1_hit    = id_use_rs1_i & (id_rs1_idx_i == ex_rd_idx_i);
    rs2_hit    = id_use_rs2_i & (id_rs2_idx_i == ex_rd_idx_i);
    load_use_o = ex_is_load_i & rd_nonzero & (rs1_hit | rs2_hit);
  end

endmodule

// File: rtl/pipeline_interlock_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flush, memory freeze.
// Optional performance counters enabled by defining PIPE_INTERLOCK_PERF_EN.
module pipeline_interlock_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_IDX_W         = 5,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic [REG_IDX_W-1:0] id_rs1_idx_i,
  input  logic [REG_IDX_W-1:0] id_rs2_idx_i,
  input  logic                 id_use_rs1_i,
  input  logic                 id_use_rs2_i,
  input  logic [REG_IDX_W-1:0] ex_rd_idx_i,
  input  logic                 ex_is_load_i,
  input  logic                 ex_branch_taken_i,
  input  logic                 mem_req_i,
  input  logic                 mem_ready_i,
  output logic                 stall_if_o,
  output logic                 stall_id_o,
  output logic                 bubble_ex_o,
  output logic                 stall_ex_o,
  output logic                 stall_mem_o,
  output logic                 flush_if_o,
  output logic                 flush_id_o,
  output logic [CNT_W-1:0]     stall_cycles_o,
  output logic [CNT_W-1:0]     flush_count_o
);

  localparam int unsigned LSC_EFF = clamp_load_stall(LOAD_STALL_CYCLES);
  localparam bit          MULTI_BUBBLE = (LSC_EFF > 1);
  localparam logic [LU_CNT_W-1:0] LU_RELOAD = LU_CNT_W'(LSC_EFF - 1);

  interlock_state_e state_q, state_d;
  interlock_state_e ret_q, ret_d;
  logic [LU_CNT_W-1:0] cnt_q, cnt_d;

  logic load_use;
  logic mem_busy;

  logic stall_if, stall_id, bubble_ex, stall_ex, stall_mem, flush_if, flush_id;

  load_use_detect #(
    .REG_IDX_W (REG_IDX_W)
  ) u_load_use_detect (
    .id_rs1_idx_i (id_rs1_idx_i),
    .id_rs2_idx_i (id_rs2_idx_i),
    .id_use_rs1_i (id_use_rs1_i),
    .id_use_rs2_i (id_use_rs2_i),
    .ex_rd_idx_i  (ex_rd_idx_i),
    .ex_is_load_i (ex_is_load_i),
    .load_use_o   (load_use)
  );

  assign mem_busy = mem_req_i & ~mem_ready_i;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= RUN;
      ret_q   <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    cnt_d     = cnt_q;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_if  = 1'b0;
    flush_id  = 1'b0;

    unique case (state_q)
      RUN: begin
        if (mem_busy) begin
          {stall_if, stall_id, stall_ex, stall_mem} = '1;
          ret_d   = RUN;
          state_d = MEM_WAIT;
        end else if (ex_branch_taken_i) begin
          flush_if = 1'b1;
          flush_id = 1'b1;
        end else if (load_use) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
          if (MULTI_BUBBLE) begin
            state_d = LU_STALL;
            cnt_d   = LU_RELOAD;
          end
        end
      end

      LU_STALL: begin
        // A memory freeze holds the remaining bubble count untouched.
        if (mem_busy) begin
          {stall_if, stall_id, stall_ex, stall_mem} = '1;
          ret_d   = LU_STALL;
          state_d = MEM_WAIT;
        end else begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
          if (cnt_q <= LU_CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - LU_CNT_W'(1);
          end
        end
      end

      MEM_WAIT: begin
        {stall_if, stall_id, stall_ex, stall_mem} = {4{~mem_ready_i}};
        if (mem_ready_i) begin
          state_d = ret_q;
        end
      end

      default: begin
        state_d = RUN;
        ret_d   = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset forces every control low immediately, independent of the clock.
  assign stall_if_o  = stall_if  & reset_ni;
  assign stall_id_o  = stall_id  & reset_ni;
  assign bubble_ex_o = bubble_ex & reset_ni;
  assign stall_ex_o  = stall_ex  & reset_ni;
  assign stall_mem_o = stall_mem & reset_ni;
  assign flush_if_o  = flush_if  & reset_ni;
  assign flush_id_o  = flush_id  & reset_ni;

`ifdef PIPE_INTERLOCK_PERF_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + CNT_W'(stall_if_o);
    flush_count_d  = flush_count_q + CNT_W'(flush_if_o);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_count_o  = flush_count_q;
`else
  assign stall_cycles_o = '0;
  assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_pipeline_interlock_ctrl.sv
// Self-checking bench: two instances (1 and 3 load-use bubbles) against a pending-bubble model.
module tb_pipeline_interlock_ctrl;

  localparam int CW = 8;

  // Control vector layout: {stall_if, stall_id, bubble_ex, stall_ex, stall_mem, flush_if, flush_id}
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] BUB  = 7'b1110000;
  localparam logic [6:0] FULL = 7'b1101100;
  localparam logic [6:0] FL   = 7'b0000011;

  logic clk_i = 1'b0;
  logic reset_ni = 1'b0;
  logic [4:0] rs1, rs2, rd;
  logic use1, use2, is_load, br, req, rdy;

  wire [6:0]    ctl1, ctl3;
  wire [CW-1:0] sc1, fc1, sc3, fc3;

  always #5 clk_i = ~clk_i;

  pipeline_interlock_ctrl #(
    .REG_IDX_W(5), .LOAD_STALL_CYCLES(1), .CNT_W(CW)
  ) u1 (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .id_rs1_idx_i(rs1), .id_rs2_idx_i(rs2),
    .id_use_rs1_i(use1), .id_use_rs2_i(use2),
    .ex_rd_idx_i(rd), .ex_is_load_i(is_load),
    .ex_branch_taken_i(br), .mem_req_i(req), .mem_ready_i(rdy),
    .stall_if_o(ctl1[6]), .stall_id_o(ctl1[5]), .bubble_ex_o(ctl1[4]),
    .stall_ex_o(ctl1[3]), .stall_mem_o(ctl1[2]),
    .flush_if_o(ctl1[1]), .flush_id_o(ctl1[0]),
    .stall_cycles_o(sc1), .flush_count_o(fc1)
  );

  pipeline_interlock_ctrl #(
    .REG_IDX_W(5), .LOAD_STALL_CYCLES(3), .CNT_W(CW)
  ) u3 (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .id_rs1_idx_i(rs1), .id_rs2_idx_i(rs2),
    .id_use_rs1_i(use1), .id_use_rs2_i(use2),
    .ex_rd_idx_i(rd), .ex_is_load_i(is_load),
    .ex_branch_taken_i(br), .mem_req_i(req), .mem_ready_i(rdy),
    .stall_if_o(ctl3[6]), .stall_id_o(ctl3[5]), .bubble_ex_o(ctl3[4]),
    .stall_ex_o(ctl3[3]), .stall_mem_o(ctl3[2]),
    .flush_if_o(ctl3[1]), .flush_id_o(ctl3[0]),
    .stall_cycles_o(sc3), .flush_count_o(fc3)
  );

  // Model: number of bubbles still owed, plus whether a memory wait is in progress.
  int          pend[2];
  bit          waiting[2];
  int          lsc[2] = '{1, 3};
  logic [CW-1:0] msc[2], mfc[2];

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic bit model_lu();
    return is_load && (rd != 0) && ((use1 && rs1 == rd) || (use2 && rs2 == rd));
  endfunction

  function automatic logic [6:0] model_out(input int k);
    if (!reset_ni)       return NONE;
    if (waiting[k])      return rdy ? NONE : FULL;
    if (req && !rdy)     return FULL;
    if (pend[k] > 0)     return BUB;
    if (br)              return FL;
    if (model_lu())      return BUB;
    return NONE;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pend[k] = 0; waiting[k] = 1'b0; msc[k] = '0; mfc[k] = '0;
    end
  endtask

  task automatic model_step(input int k, input logic [6:0] o);
    msc[k] = msc[k] + CW'(o[6]);
    mfc[k] = mfc[k] + CW'(o[1]);
    if (waiting[k]) begin
      if (rdy) waiting[k] = 1'b0;
    end else if (req && !rdy) begin
      waiting[k] = 1'b1;
    end else if (pend[k] > 0) begin
      pend[k]--;
    end else if (!br && model_lu()) begin
      pend[k] = lsc[k] - 1;
    end
  endtask

  // One clock cycle: compare at the falling edge, then advance the model.
  task automatic cyc(input bit use_lit, input logic [6:0] l1, input logic [6:0] l3);
    logic [6:0] o0, o1;
    @(negedge clk_i);
    o0 = model_out(0);
    o1 = model_out(1);
    check("u1_ctl", ctl1, o0);
    check("u3_ctl", ctl3, o1);
`ifdef PIPE_INTERLOCK_PERF_EN
    check("u1_stall_cnt", sc1, msc[0]);
    check("u1_flush_cnt", fc1, mfc[0]);
    check("u3_stall_cnt", sc3, msc[1]);
    check("u3_flush_cnt", fc3, mfc[1]);
`else
    check("u1_stall_cnt", sc1, 0);
    check("u3_flush_cnt", fc3, 0);
`endif
    if (use_lit) begin
      check("u1_lit", ctl1, l1);
      check("u3_lit", ctl3, l3);
    end
    model_step(0, o0);
    model_step(1, o1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    rs1 = '0; rs2 = '0; rd = '0;
    use1 = 1'b0; use2 = 1'b0; is_load = 1'b0; br = 1'b0; req = 1'b0; rdy = 1'b0;
  endtask

  task automatic hazard();
    idle();
    is_load = 1'b1; rd = 5'd5; rs1 = 5'd5; use1 = 1'b1;
  endtask

  // Asynchronous reset pulse inserted mid-cycle.
  task automatic rst_pulse();
    #2 reset_ni = 1'b0;
    #1;
    check("rst_u1_ctl", ctl1, NONE);
    check("rst_u3_ctl", ctl3, NONE);
    check("rst_u3_stall_cnt", sc3, 0);
    model_reset();
    @(posedge clk_i);
    #2 reset_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    hazard();
    req = 1'b1;
    #1;
    check("in_reset_u1_ctl", ctl1, NONE);
    check("in_reset_u3_ctl", ctl3, NONE);
    @(posedge clk_i);
    #2 reset_ni = 1'b1;

    // Single load-use hazard, then the ID instruction proceeds.
    hazard(); cyc(1, BUB, BUB);
    idle();   cyc(1, NONE, BUB);
              cyc(1, NONE, BUB);
              cyc(1, NONE, NONE);

    // Load to x0 and unused source never stall; rs2 match does.
    idle(); is_load = 1'b1; use2 = 1'b1; cyc(1, NONE, NONE);
    idle(); is_load = 1'b1; rd = 5'd7; rs1 = 5'd7; cyc(1, NONE, NONE);
    idle(); is_load = 1'b1; rd = 5'd9; rs2 = 5'd9; use2 = 1'b1; cyc(1, BUB, BUB);
    idle(); cyc(1, NONE, BUB); cyc(1, NONE, BUB); cyc(1, NONE, NONE);

    // Taken branch wins over a coincident load-use.
    hazard(); br = 1'b1; cyc(1, FL, FL);
    idle();   cyc(1, NONE, NONE);

    // Four cycles of memory back-pressure, then completion.
    idle(); req = 1'b1;
    repeat (4) cyc(1, FULL, FULL);
    rdy = 1'b1; cyc(1, NONE, NONE);
    idle();     cyc(1, NONE, NONE);

    // Memory stall arriving on the second bubble; remaining bubbles resume afterwards.
    hazard(); cyc(1, BUB, BUB);
    idle(); req = 1'b1;
    cyc(1, FULL, FULL); cyc(1, FULL, FULL); cyc(1, FULL, FULL);
    rdy = 1'b1; cyc(1, NONE, NONE);
    idle(); cyc(1, NONE, BUB); cyc(1, NONE, BUB); cyc(1, NONE, NONE);

    // Same scenario with reset during the memory wait: nothing is remembered.
    hazard(); cyc(1, BUB, BUB);
    idle(); req = 1'b1;
    cyc(1, FULL, FULL); cyc(1, FULL, FULL);
    rst_pulse();
    idle();
    cyc(1, NONE, NONE); cyc(1, NONE, NONE); cyc(1, NONE, NONE);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      rs1     = 5'($urandom_range(0, 3));
      rs2     = 5'($urandom_range(0, 3));
      rd      = 5'($urandom_range(0, 3));
      use1    = ($urandom_range(0, 3) != 0);
      use2    = ($urandom_range(0, 1) != 0);
      is_load = ($urandom_range(0, 1) != 0);
      br      = ($urandom_range(0, 9) < 2);
      req     = ($urandom_range(0, 9) < 3);
      rdy     = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 199) == 0) rst_pulse();
      cyc(0, NONE, NONE);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
